mul_div_unit: RTL and testbench

- Execute-stage HI/LO unit. Consumes the 8-bit one-hot MDop produced by the ID control decoder, plus the rs and rt operand values.
- Performs MULT/MULTU over a fixed number of cycles and DIV/DIVU iteratively. Owns the architectural HI/LO registers and serves MFHI/MFLO/MTHI/MTLO.
- Drives a ready/stall handshake back to the pipeline while a long operation is in flight.

---
 rtl/mul_div_unit_pkg.sv | 47 ++++
 rtl/mul_div_unit_divider.sv | 76 +++++++
 rtl/mul_div_unit.sv | 167 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the execute-stage HI/LO unit: MDop bit indices,
// unit states, divider iteration count and a priority decoder for md_op.
package mul_div_unit_pkg;

  localparam int MD_DIV   = 7;
  localparam int MD_DIVU  = 6;
  localparam int MD_MULT  = 5;
  localparam int MD_MULTU = 4;
  localparam int MD_MFHI  = 3;
  localparam int MD_MFLO  = 2;
  localparam int MD_MTHI  = 1;
  localparam int MD_MTLO  = 0;

  localparam int DIV_ITER = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  typedef enum logic [3:0] {
    CMD_NONE,
    CMD_DIV,
    CMD_DIVU,
    CMD_MULT,
    CMD_MULTU,
    CMD_MFHI,
    CMD_MFLO,
    CMD_MTHI,
    CMD_MTLO
  } md_cmd_e;

  // md_op should be one-hot; if it is not, the highest set bit is honoured
  function automatic md_cmd_e md_decode(input logic [7:0] op);
    if (op[MD_DIV])        return CMD_DIV;
    else if (op[MD_DIVU])  return CMD_DIVU;
    else if (op[MD_MULT])  return CMD_MULT;
    else if (op[MD_MULTU]) return CMD_MULTU;
    else if (op[MD_MFHI])  return CMD_MFHI;
    else if (op[MD_MFLO])  return CMD_MFLO;
    else if (op[MD_MTHI])  return CMD_MTHI;
    else if (op[MD_MTLO])  return CMD_MTLO;
    else                   return CMD_NONE;
  endfunction

endpackage

// File: rtl/mul_div_unit_divider.sv
// md_divider: iterative unsigned radix-2 restoring divider, one quotient bit
// per cycle for DIV_ITER cycles; done pulses for one cycle with the result.
module md_divider
  import mul_div_unit_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int IW = $clog2(DIV_ITER);

  logic [W-1:0]  rem_q;
  logic [W-1:0]  quo_q;
  logic [W-1:0]  dsr_q;
  logic [IW-1:0] iter_q;
  logic          busy_q;
  logic          done_q;

  logic [W:0]    shifted;
  logic          take;
  logic [W-1:0]  rem_next;

  // The partial remainder is shifted one bit wider than W so the trial
  // subtraction never overflows, even for divisors with the MSB set.
  always_comb begin
    shifted  = {rem_q, quo_q[W-1]};
    take     = (shifted >= {1'b0, dsr_q});
    rem_next = take ? W'(shifted - {1'b0, dsr_q}) : shifted[W-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        busy_q <= 1'b0;
      end else if (start) begin
        busy_q <= 1'b1;
        rem_q  <= '0;
        quo_q  <= dividend;
        dsr_q  <= divisor;
        iter_q <= '0;
      end else if (busy_q) begin
        rem_q  <= rem_next;
        quo_q  <= {quo_q[W-2:0], take};
        iter_q <= iter_q + 1'b1;
        if (iter_q == IW'(DIV_ITER - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// Execute-stage HI/LO unit: multi-cycle MULT/MULTU, iterative DIV/DIVU,
// MFHI/MFLO/MTHI/MTLO. Optional stall counter under `MD_STALL_CNT_EN.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              md_valid,
  input  logic [7:0]        md_op,
  input  logic [DATA_W-1:0] md_rs,
  input  logic [DATA_W-1:0] md_rt,
  input  logic              md_cancel,
  output logic              md_ready,
  output logic [DATA_W-1:0] md_result,
  output logic [31:0]       md_stall_cnt
);

  md_state_e state_q, state_d;
  md_cmd_e   cmd;
  logic      accept;

  logic [DATA_W-1:0]   hi_q, lo_q;
  logic [DATA_W-1:0]   mul_a_q, mul_b_q;
  logic                mul_signed_q;
  logic [2:0]          mul_cnt_q;
  logic [2*DATA_W-1:0] mul_prod;
  logic                mul_fin, div_fin;

  logic [DATA_W-1:0] rs_raw_q;
  logic              q_neg_q, r_neg_q, dbz_q;
  logic              rs_neg, rt_neg;
  logic              div_start, div_busy, div_done;
  logic [DATA_W-1:0] div_dividend, div_divisor, div_quo, div_rem;

  assign cmd      = md_decode(md_op);
  assign md_ready = (state_q == ST_IDLE);
  assign accept   = md_valid && md_ready && !md_cancel;

  // Operand sign-extension is gated by signedness so one multiplier serves both
  assign mul_prod = {{DATA_W{mul_signed_q & mul_a_q[DATA_W-1]}}, mul_a_q} *
                    {{DATA_W{mul_signed_q & mul_b_q[DATA_W-1]}}, mul_b_q};

  assign rs_neg       = (cmd == CMD_DIV) && md_rs[DATA_W-1];
  assign rt_neg       = (cmd == CMD_DIV) && md_rt[DATA_W-1];
  assign div_dividend = rs_neg ? -md_rs : md_rs;
  assign div_divisor  = rt_neg ? -md_rt : md_rt;
  assign div_start    = accept && (cmd == CMD_DIV || cmd == CMD_DIVU);

  md_divider #(.W(DATA_W)) u_divider (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .abort     (md_cancel),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // A cancel in a busy state always wins over the final result write
  always_comb begin
    state_d = state_q;
    mul_fin = 1'b0;
    div_fin = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && (cmd == CMD_MULT || cmd == CMD_MULTU)) state_d = ST_MUL;
        else if (div_start)                                  state_d = ST_DIV;
      end
      ST_MUL: begin
        if (md_cancel) begin
          state_d = ST_IDLE;
        end else if (mul_cnt_q == 3'd0) begin
          state_d = ST_IDLE;
          mul_fin = 1'b1;
        end
      end
      ST_DIV: begin
        if (md_cancel) begin
          state_d = ST_IDLE;
        end else if (div_done && !div_busy) begin
          state_d = ST_IDLE;
          div_fin = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q         <= '0;
      lo_q         <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_signed_q <= 1'b0;
      mul_cnt_q    <= '0;
      rs_raw_q     <= '0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
      dbz_q        <= 1'b0;
    end else begin
      if (accept) begin
        case (cmd)
          CMD_MTHI: hi_q <= md_rs;
          CMD_MTLO: lo_q <= md_rs;
          CMD_MULT, CMD_MULTU: begin
            mul_a_q      <= md_rs;
            mul_b_q      <= md_rt;
            mul_signed_q <= (cmd == CMD_MULT);
            mul_cnt_q    <= 3'(MUL_CYCLES - 1);
          end
          CMD_DIV, CMD_DIVU: begin
            rs_raw_q <= md_rs;
            q_neg_q  <= rs_neg ^ rt_neg;
            r_neg_q  <= rs_neg;
            dbz_q    <= (md_rt == '0);
          end
          default: ;
        endcase
      end
      if (state_q == ST_MUL && !md_cancel && mul_cnt_q != 3'd0)
        mul_cnt_q <= mul_cnt_q - 3'd1;
      if (mul_fin) {hi_q, lo_q} <= mul_prod;
      // Zero divisor bypasses the sign fix-up and reports the raw dividend
      if (div_fin) begin
        if (dbz_q) begin
          lo_q <= '1;
          hi_q <= rs_raw_q;
        end else begin
          lo_q <= q_neg_q ? -div_quo : div_quo;
          hi_q <= r_neg_q ? -div_rem : div_rem;
        end
      end
    end
  end

  always_comb begin
    md_result = '0;
    if (accept && cmd == CMD_MFHI)      md_result = hi_q;
    else if (accept && cmd == CMD_MFLO) md_result = lo_q;
  end

`ifdef MD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                    stall_cnt_q <= '0;
    else if (md_valid && !md_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign md_stall_cnt = stall_cnt_q;
`else
  assign md_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random
// instruction streams against a plain-arithmetic HI/LO reference model.
module tb_mul_div_unit;

  localparam int MUL_CYCLES = 2;
  localparam int DIV_CYCLES = 33;

  localparam logic [7:0] OP_DIV   = 8'h80;
  localparam logic [7:0] OP_DIVU  = 8'h40;
  localparam logic [7:0] OP_MULT  = 8'h20;
  localparam logic [7:0] OP_MULTU = 8'h10;
  localparam logic [7:0] OP_MFHI  = 8'h08;
  localparam logic [7:0] OP_MFLO  = 8'h04;
  localparam logic [7:0] OP_MTHI  = 8'h02;
  localparam logic [7:0] OP_MTLO  = 8'h01;

`ifdef MD_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        md_valid;
  logic [7:0]  md_op;
  logic [31:0] md_rs;
  logic [31:0] md_rt;
  logic        md_cancel;
  logic        md_ready;
  logic [31:0] md_result;
  logic [31:0] md_stall_cnt;

  int checks = 0;
  int passes = 0;

  logic [31:0] exp_hi, exp_lo;
  logic [31:0] save_hi, save_lo;

  mul_div_unit #(.MUL_CYCLES(MUL_CYCLES), .DATA_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .md_valid     (md_valid),
    .md_op        (md_op),
    .md_rs        (md_rs),
    .md_rt        (md_rt),
    .md_cancel    (md_cancel),
    .md_ready     (md_ready),
    .md_result    (md_result),
    .md_stall_cnt (md_stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: run still active at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [7:0] top_op(input logic [7:0] op);
    for (int i = 7; i >= 0; i--)
      if (op[i]) return 8'(1 << i);
    return 8'h00;
  endfunction

  function automatic int exp_latency(input logic [7:0] op);
    logic [7:0] t;
    t = top_op(op);
    if (t == OP_MULT || t == OP_MULTU) return MUL_CYCLES;
    if (t == OP_DIV || t == OP_DIVU)   return DIV_CYCLES;
    return 0;
  endfunction

  // Reference model: architectural HI/LO effect of one accepted instruction
  task automatic model_apply(input logic [7:0] op, input logic [31:0] rs, input logic [31:0] rt);
    logic signed [31:0] a, b, q, r;
    logic signed [63:0] a64, b64, sp;
    logic [63:0] up;
    a = rs;
    b = rt;
    case (top_op(op))
      OP_MTHI: exp_hi = rs;
      OP_MTLO: exp_lo = rs;
      OP_MULT: begin
        a64 = a;
        b64 = b;
        sp  = a64 * b64;
        {exp_hi, exp_lo} = sp;
      end
      OP_MULTU: begin
        up = {32'd0, rs} * {32'd0, rt};
        {exp_hi, exp_lo} = up;
      end
      OP_DIV: begin
        if (rt == 32'd0) begin
          exp_lo = 32'hFFFF_FFFF;
          exp_hi = rs;
        end else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
          exp_lo = 32'h8000_0000;
          exp_hi = 32'd0;
        end else begin
          q = a / b;
          r = a % b;
          exp_lo = q;
          exp_hi = r;
        end
      end
      OP_DIVU: begin
        if (rt == 32'd0) begin
          exp_lo = 32'hFFFF_FFFF;
          exp_hi = rs;
        end else begin
          exp_lo = rs / rt;
          exp_hi = rs % rt;
        end
      end
      default: ;
    endcase
  endtask

  // Presents one instruction for one cycle; called and returns just after a negedge
  task automatic applyStimulus(input string tag, input logic [7:0] op, input logic [31:0] rs,
                               input logic [31:0] rt, input bit cancel);
    logic [7:0]  t;
    logic [31:0] exp_res;
    t = top_op(op);
    exp_res = 32'd0;
    if (!cancel && t == OP_MFHI) exp_res = exp_hi;
    if (!cancel && t == OP_MFLO) exp_res = exp_lo;
    md_valid  = 1'b1;
    md_op     = op;
    md_rs     = rs;
    md_rt     = rt;
    md_cancel = cancel;
    #1;
    checkOutput({tag, ".ready"}, {31'd0, md_ready}, 32'd1);
    checkOutput({tag, ".result"}, md_result, exp_res);
    if (!cancel) model_apply(op, rs, rt);
    @(negedge clk);
    md_valid  = 1'b0;
    md_op     = 8'h00;
    md_rs     = 32'd0;
    md_rt     = 32'd0;
    md_cancel = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (!md_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    checkOutput({tag, ".busy"}, 32'(n), 32'(exp_cycles));
  endtask

  task automatic runOp(input string tag, input logic [7:0] op, input logic [31:0] rs, input logic [31:0] rt);
    applyStimulus(tag, op, rs, rt, 1'b0);
    waitIdle(tag, exp_latency(op));
  endtask

  task automatic readHiLo(input string tag);
    applyStimulus({tag, ".mfhi"}, OP_MFHI, 32'd0, 32'd0, 1'b0);
    applyStimulus({tag, ".mflo"}, OP_MFLO, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic doReset();
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    int b;
    logic [7:0] op;
    md_valid  = 1'b0;
    md_op     = 8'h00;
    md_rs     = 32'd0;
    md_rt     = 32'd0;
    md_cancel = 1'b0;
    resetn    = 1'b0;
    exp_hi    = 32'd0;
    exp_lo    = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset.ready", {31'd0, md_ready}, 32'd1);
    checkOutput("reset.result", md_result, 32'd0);
    checkOutput("reset.stall", md_stall_cnt, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    readHiLo("reset");

    $display("[TB] directed HI/LO moves and multiplies");
    runOp("mthi", OP_MTHI, 32'h0000_1234, 32'd0);
    applyStimulus("mthi.mfhi", OP_MFHI, 32'd0, 32'd0, 1'b0);
    runOp("mtlo", OP_MTLO, 32'hCAFE_F00D, 32'd0);
    readHiLo("mtlo");
    runOp("mult", OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    readHiLo("mult");
    runOp("multu", OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    readHiLo("multu");

    $display("[TB] directed divides");
    runOp("divu", OP_DIVU, 32'd100, 32'd7);
    readHiLo("divu");
    runOp("div.neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    readHiLo("div.neg");
    runOp("div.ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    readHiLo("div.ovf");
    runOp("divu.zero", OP_DIVU, 32'd7, 32'd0);
    readHiLo("divu.zero");
    runOp("div.zero", OP_DIV, 32'hFFFF_FFFB, 32'd0);
    readHiLo("div.zero");
    runOp("div.bothneg", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    readHiLo("div.bothneg");

    $display("[TB] cancel scenarios");
    applyStimulus("cancel.mtlo", OP_MTLO, 32'h1111_2222, 32'd0, 1'b1);
    readHiLo("cancel.mtlo");
    save_hi = exp_hi;
    save_lo = exp_lo;
    applyStimulus("cancel.mul", OP_MULT, 32'd12345, 32'd678, 1'b0);
    repeat (MUL_CYCLES - 1) @(negedge clk);
    md_cancel = 1'b1;
    @(negedge clk);
    md_cancel = 1'b0;
    #1;
    checkOutput("cancel.mul.ready", {31'd0, md_ready}, 32'd1);
    exp_hi = save_hi;
    exp_lo = save_lo;
    @(negedge clk);
    readHiLo("cancel.mul");
    applyStimulus("cancel.div", OP_DIVU, 32'd50, 32'd5, 1'b0);
    repeat (9) @(negedge clk);
    #1;
    checkOutput("cancel.div.busy", {31'd0, md_ready}, 32'd0);
    md_cancel = 1'b1;
    @(negedge clk);
    md_cancel = 1'b0;
    #1;
    checkOutput("cancel.div.ready", {31'd0, md_ready}, 32'd1);
    exp_hi = save_hi;
    exp_lo = save_lo;
    @(negedge clk);
    readHiLo("cancel.div");

    $display("[TB] stall counter with MFLO held during a divide");
    doReset();
    applyStimulus("stall.div", OP_DIV, 32'd1000, 32'd3, 1'b0);
    repeat (5) @(negedge clk);
    md_valid = 1'b1;
    md_op    = OP_MFLO;
    n = 0;
    while (!md_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    #1;
    checkOutput("stall.wait", 32'(n), 32'd28);
    checkOutput("stall.result", md_result, exp_lo);
    checkOutput("stall.cnt", md_stall_cnt, STALL_EN ? 32'd28 : 32'd0);
    @(negedge clk);
    md_valid = 1'b0;
    md_op    = 8'h00;
    readHiLo("stall");

    $display("[TB] reset during a divide");
    runOp("prereset", OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    applyStimulus("rst.div", OP_DIV, 32'd99, 32'd4, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("rst.ready", {31'd0, md_ready}, 32'd1);
    checkOutput("rst.stall", md_stall_cnt, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    readHiLo("rst");

    $display("[TB] random instruction stream");
    for (int i = 0; i < 60; i++) begin
      b  = $urandom_range(0, 7);
      op = 8'(1 << b);
      if (b > 0 && $urandom_range(0, 4) == 0) op = op | (8'($urandom) & 8'((1 << b) - 1));
      runOp($sformatf("rnd%0d", i), op, rand_val(), rand_val());
      if (i % 4 == 3) readHiLo($sformatf("rnd%0d", i));
    end
    readHiLo("rnd.end");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
